// File: rtl/counter_sequencer_if.sv
// Control/status bundle between the board top level and counter_sequencer.
// master: board side (buttons, counter Q feedback); slave: the sequencer.
interface counter_sequencer_if;
    logic        start_stop;
    logic        clear;
    logic [15:0] count_q;
    logic        cnt_en;
    logic        cnt_clr_n;
    logic        running;
    logic        done;

    modport master (
        output start_stop, clear, count_q,
        input  cnt_en, cnt_clr_n, running, done
    );

    modport slave (
        input  start_stop, clear, count_q,
        output cnt_en, cnt_clr_n, running, done
    );
endinterface

// File: rtl/counter_sequencer.sv
// Run/pause/clear sequencer for the 16-bit board counter.
// Synchronizes the start_stop/clear buttons, prescales a one-cycle count
// enable by TICK_DIV while running, and issues a one-cycle active-low clear.
// Optional stop-at-target (DONE state) is compiled in with the macro
// COUNTER_SEQ_AUTOSTOP_EN; without it done is tied low and count_q is unused.
module counter_sequencer #(
    parameter int unsigned TICK_DIV = 4,
    parameter logic [15:0] TARGET   = 16'd5
) (
    input  logic              Clock,
    input  logic              Resetn,
    counter_sequencer_if.slave bus
);
    localparam int unsigned   DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
`ifdef COUNTER_SEQ_AUTOSTOP_EN
        DONE  = 2'd3,
`endif
        PAUSE = 2'd2
    } state_t;

    // Reject out-of-range configuration at elaboration.
    if (TICK_DIV < 1 || TICK_DIV > (1 << 26)) begin : g_bad_tick_div
        $error("counter_sequencer: TICK_DIV out of range");
    end
    if (TARGET == 16'd0) begin : g_bad_target
        $error("counter_sequencer: TARGET must be nonzero");
    end

    state_t           state;
    state_t           state_nxt_c;
    logic [DIV_W-1:0] div_cnt;
    logic [2:0]       ss_pipe;     // [0] meta, [1] synced, [2] previous synced
    logic [2:0]       clr_pipe;
    logic             ss_evt_c;
    logic             clr_evt_c;
    logic             div_wrap_c;
    logic             tick_c;
    logic             div_zero_c;

    assign ss_evt_c   = ss_pipe[1]  & ~ss_pipe[2];
    assign clr_evt_c  = clr_pipe[1] & ~clr_pipe[2];
    assign div_wrap_c = (div_cnt == DIV_LAST);

`ifdef COUNTER_SEQ_AUTOSTOP_EN
    logic target_hit_c;
    // A tick now brings Q to at least TARGET on the following edge.
    assign target_hit_c = (bus.count_q >= (TARGET - 16'd1));
`endif

    // Next state and tick decision; clear wins over start_stop.
    always_comb begin
        state_nxt_c = state;
        tick_c      = 1'b0;
        if (clr_evt_c) begin
            state_nxt_c = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (ss_evt_c) state_nxt_c = RUN;
                end
                RUN: begin
                    if (ss_evt_c) begin
                        state_nxt_c = PAUSE;
                    end else if (div_wrap_c) begin
                        tick_c = 1'b1;
`ifdef COUNTER_SEQ_AUTOSTOP_EN
                        if (target_hit_c) state_nxt_c = DONE;
`endif
                    end
                end
                PAUSE: begin
                    if (ss_evt_c) state_nxt_c = RUN;
                end
                default: state_nxt_c = state;
            endcase
        end
    end

    // Prescaler restarts from zero whenever the sequencer lands in IDLE or DONE.
    always_comb begin
        div_zero_c = (state_nxt_c == IDLE);
`ifdef COUNTER_SEQ_AUTOSTOP_EN
        if (state_nxt_c == DONE) div_zero_c = 1'b1;
`endif
    end

    // Synchronizers, state, prescaler and registered outputs.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            ss_pipe       <= 3'b000;
            clr_pipe      <= 3'b000;
            state         <= IDLE;
            div_cnt       <= '0;
            bus.cnt_en    <= 1'b0;
            bus.cnt_clr_n <= 1'b0;
            bus.running   <= 1'b0;
            bus.done      <= 1'b0;
        end else begin
            ss_pipe       <= {ss_pipe[1:0], bus.start_stop};
            clr_pipe      <= {clr_pipe[1:0], bus.clear};
            state         <= state_nxt_c;
            bus.cnt_en    <= tick_c;
            bus.cnt_clr_n <= ~clr_evt_c;
            bus.running   <= (state_nxt_c == RUN);
`ifdef COUNTER_SEQ_AUTOSTOP_EN
            bus.done      <= (state_nxt_c == DONE);
`else
            bus.done      <= 1'b0;
`endif
            if (div_zero_c) begin
                div_cnt <= '0;
            end else if (state == RUN) begin
                div_cnt <= div_wrap_c ? '0 : div_cnt + DIV_W'(1);
            end
        end
    end
endmodule
